// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: restoring radix-2, one quotient bit per clock, then RNE; one op in flight.
// Latency MW+4 edges (specials 0), result held in DONE until out_ready; in_ready only while idle.
module fp_div_seq #(
   parameter int IS_DOUBLE  = 0,
   parameter int EXP_WIDTH  = (IS_DOUBLE == 1) ? 11 : 8,
   parameter int MANT_WIDTH = (IS_DOUBLE == 1) ? 52 : 23,
   parameter int WIDTH      = 1 + EXP_WIDTH + MANT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero,
   output logic             overflow,
   output logic             underflow,
   output logic             invalid
);
   localparam int MW   = MANT_WIDTH;
   localparam int EW   = EXP_WIDTH;
   localparam int XW   = EW + 2;
   localparam int QW   = MW + 3;
   localparam int RW   = MW + 2;
   localparam int CW   = $clog2(QW);
   localparam int BIAS = (1 << (EW - 1)) - 1;
   localparam logic [WIDTH-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_sign;
   logic signed [XW-1:0] r_exp;
   logic [MW:0]          r_mb;
   logic [RW-1:0]        r_rem;
   logic [QW-1:0]        r_q;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_result;
   logic                 r_dbz, r_ovf, r_udf, r_inv;

   // Operand decode; subnormal inputs are treated as zero
   logic [EW-1:0] w_ea, w_eb;
   logic [MW-1:0] w_fa, w_fb;
   logic          w_sign;
   logic          w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
   logic signed [XW-1:0] w_exp_in;

   assign w_ea     = a[WIDTH-2 -: EW];
   assign w_eb     = b[WIDTH-2 -: EW];
   assign w_fa     = a[MW-1:0];
   assign w_fb     = b[MW-1:0];
   assign w_sign   = a[WIDTH-1] ^ b[WIDTH-1];
   assign w_a_zero = (w_ea == '0);
   assign w_b_zero = (w_eb == '0);
   assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
   assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
   assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
   assign w_b_nan  = (w_eb == '1) && (w_fb != '0);
   assign w_a_snan = w_a_nan && !w_fa[MW-1];
   assign w_b_snan = w_b_nan && !w_fb[MW-1];
   assign w_exp_in = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + XW'(BIAS);

   logic             w_spec, w_spec_dbz, w_spec_inv;
   logic [WIDTH-1:0] w_spec_res;

   always_comb begin
      w_spec     = 1'b1;
      w_spec_res = '0;
      w_spec_dbz = 1'b0;
      w_spec_inv = 1'b0;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_spec_res = QNAN;
         w_spec_inv = w_a_snan | w_b_snan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
      end else if (w_b_zero && !w_a_inf) begin
         w_spec_res = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
         w_spec_dbz = 1'b1;
      end else if (w_a_inf) begin
         w_spec_res = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
      end else if (w_b_inf || w_a_zero) begin
         w_spec_res = {w_sign, {(WIDTH-1){1'b0}}};
      end else begin
         w_spec = 1'b0;
      end
   end

   // Restoring step: remainder stays below 2*mb, so RW bits suffice
   logic          w_qbit;
   logic [RW-1:0] w_rem_sub;

   assign w_qbit    = (r_rem >= {1'b0, r_mb});
   assign w_rem_sub = w_qbit ? (r_rem - {1'b0, r_mb}) : r_rem;

   logic [MW-1:0]        w_frac;
   logic                 w_g, w_s, w_inc;
   logic signed [XW-1:0] w_e, w_e_r;
   logic [MW:0]          w_frac_inc;
   logic                 w_ovf, w_udf;
   logic [WIDTH-1:0]     w_round_res;

   always_comb begin
      if (r_q[QW-1]) begin
         w_frac = r_q[QW-2:2];
         w_g    = r_q[1];
         w_s    = r_q[0] | (|r_rem);
         w_e    = r_exp;
      end else begin
         w_frac = r_q[QW-3:1];
         w_g    = r_q[0];
         w_s    = |r_rem;
         w_e    = r_exp - XW'(1);
      end
   end

   assign w_inc      = w_g & (w_s | w_frac[0]);
   assign w_frac_inc = {1'b0, w_frac} + {{MW{1'b0}}, w_inc};
   assign w_e_r      = w_e + $signed({{(XW-1){1'b0}}, w_frac_inc[MW]});
   assign w_ovf      = (w_e_r >= XW'((1 << EW) - 1));
   assign w_udf      = w_e_r[XW-1] || (w_e_r == '0);

   always_comb begin
      if (w_ovf)
         w_round_res = {r_sign, {EW{1'b1}}, {MW{1'b0}}};
      else if (w_udf)
         w_round_res = {r_sign, {(WIDTH-1){1'b0}}};
      else
         w_round_res = {r_sign, w_e_r[EW-1:0], w_frac_inc[MW-1:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_state_nxt = w_spec ? S_DONE : S_DIV;
         S_DIV:   if (r_cnt == CW'(QW - 1)) w_state_nxt = S_ROUND;
         S_ROUND: w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE:  in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_mb     <= '0;
         r_rem    <= '0;
         r_q      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_dbz    <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_inv    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_sign <= w_sign;
               r_exp  <= w_exp_in;
               r_mb   <= {1'b1, w_fb};
               r_rem  <= {1'b0, 1'b1, w_fa};
               r_q    <= '0;
               r_cnt  <= '0;
               if (w_spec) begin
                  r_result <= w_spec_res;
                  r_dbz    <= w_spec_dbz;
                  r_ovf    <= 1'b0;
                  r_udf    <= 1'b0;
                  r_inv    <= w_spec_inv;
               end
            end
            S_DIV: begin
               r_rem <= {w_rem_sub[RW-2:0], 1'b0};
               r_q   <= {r_q[QW-2:0], w_qbit};
               r_cnt <= r_cnt + CW'(1);
            end
            S_ROUND: begin
               r_result <= w_round_res;
               r_dbz    <= 1'b0;
               r_ovf    <= w_ovf;
               r_udf    <= w_udf;
               r_inv    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign result      = r_result;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;
   assign underflow   = r_udf;
   assign invalid     = r_inv;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed fp32 vectors, random fp32 against an exact-division model, backpressure, reset, fp64.
module tb_fp_div_seq;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic        dbz, ovf, udf, inv;
   logic [3:0]  flags;
   logic        d_in_valid, d_in_ready, d_out_valid;
   logic [63:0] d_a, d_b, d_result;
   logic        d_dbz, d_ovf, d_udf, d_inv;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;
   assign flags = {dbz, ovf, udf, inv};

   fp_div_seq #(.IS_DOUBLE(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .div_by_zero(dbz),
      .overflow(ovf), .underflow(udf), .invalid(inv));

   fp_div_seq #(.IS_DOUBLE(1)) dut_dp (
      .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
      .out_valid(d_out_valid), .out_ready(1'b1), .result(d_result), .div_by_zero(d_dbz),
      .overflow(d_ovf), .underflow(d_udf), .invalid(d_inv));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
      return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
   endfunction

   // Reference: exact integer quotient of the significands with a remainder-based RNE decision.
   // Returns {result[31:0], div_by_zero, overflow, underflow, invalid}.
   function automatic logic [35:0] ref_div(input logic [31:0] x, input logic [31:0] y);
      logic   sgn;
      int     ex, ey, e;
      longint mx, my, num, q, r;
      bit     xz, yz, xi, yi, xn, yn, xs, ys;
      sgn = x[31] ^ y[31];
      ex  = int'(x[30:23]);
      ey  = int'(y[30:23]);
      xz  = (ex == 0);
      yz  = (ey == 0);
      xi  = (ex == 255) && (x[22:0] == 0);
      yi  = (ey == 255) && (y[22:0] == 0);
      xn  = (ex == 255) && (x[22:0] != 0);
      yn  = (ey == 255) && (y[22:0] != 0);
      xs  = xn && !x[22];
      ys  = yn && !y[22];
      if (xn || yn || (xz && yz) || (xi && yi))
         return {32'h7FC00000, 3'b000, xs | ys | (xz && yz) | (xi && yi)};
      if (yz && !xi) return {sgn, 8'hFF, 23'h0, 4'b1000};
      if (xi)        return {sgn, 8'hFF, 23'h0, 4'b0000};
      if (yi || xz)  return {sgn, 31'h0, 4'b0000};
      mx = longint'({1'b1, x[22:0]});
      my = longint'({1'b1, y[22:0]});
      e  = ex - ey + 127;
      if (mx < my) begin
         num = mx << 24;
         e   = e - 1;
      end else begin
         num = mx << 23;
      end
      q = num / my;
      r = num % my;
      if ((2 * r > my) || ((2 * r == my) && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {sgn, 8'hFF, 23'h0, 4'b0100};
      if (e <= 0)   return {sgn, 31'h0, 4'b0010};
      return {sgn, 8'(e), q[22:0], 4'b0000};
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [7:0]  e;
      logic [22:0] f;
      int          k;
      k = int'($urandom_range(0, 15));
      f = 23'($urandom);
      case (k)
         0:       e = 8'h00;
         1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
         2:       begin e = 8'(($urandom_range(0, 1) == 1) ? 127 : 128); f = 23'($urandom_range(0, 3) << 20); end
         default: e = 8'($urandom_range(1, 254));
      endcase
      return {1'($urandom_range(0, 1)), e, f};
   endfunction

   task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [35:0] expv,
                         input int hold, input string tag);
      int          lat;
      logic [31:0] res0;
      logic [3:0]  fl0;
      @(negedge clk);
      a = xa; b = xb; in_valid = 1'b1;
      lat = 0;
      while (!in_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), is_special(xa, xb) ? 64'd0 : 64'd27);
      check({tag, "_res"}, 64'(result), 64'(expv[35:4]));
      check({tag, "_flg"}, 64'(flags), 64'(expv[3:0]));
      res0 = result;
      fl0  = flags;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
         @(posedge clk); #1;
         check({tag, "_hold"}, 64'({out_valid, in_ready, flags, result}), 64'({1'b1, 1'b0, fl0, res0}));
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hs"}, 64'({out_valid, in_ready}), 64'(2'b01));
      out_ready = 1'b0;
   endtask

   logic [31:0] tv_a   [14] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
                                32'h00000000, 32'h7F800000, 32'h40000000, 32'h7F000000, 32'h00800000,
                                32'h7F7FFFFF, 32'h7FC00001, 32'h7F800001, 32'h7F800000};
   logic [31:0] tv_b   [14] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000, 32'h00000000,
                                32'h00000000, 32'h7F800000, 32'h7F800000, 32'h3E800000, 32'h40000000,
                                32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000};
   logic [31:0] tv_res [14] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h7F800000, 32'hFF800000,
                                32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000,
                                32'h7F7FFFFF, 32'h7FC00000, 32'h7FC00000, 32'h7F800000};
   logic [3:0]  tv_flg [14] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000,
                                4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0010,
                                4'b0000, 4'b0000, 4'b0001, 4'b0000};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      d_in_valid = 1'b0; d_a = '0; d_b = '0;
      #1;
      check("reset", 64'({in_ready, out_valid, flags, result}), 64'({1'b1, 1'b0, 4'h0, 32'h0}));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++)
         run_op(tv_a[i], tv_b[i], {tv_res[i], tv_flg[i]}, (i == 0) ? 10 : 1, $sformatf("dir%0d", i));

      // Reset in the middle of a division, then a clean op
      @(negedge clk);
      a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid", 64'({out_valid, in_ready, flags, result}), 64'({1'b0, 1'b1, 4'h0, 32'h0}));
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'h40C00000, 32'h40000000, {32'h40400000, 4'b0000}, 0, "post_rst");

      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra, rb;
         ra = rnd_fp();
         rb = rnd_fp();
         run_op(ra, rb, ref_div(ra, rb), int'($urandom_range(0, 2)), $sformatf("rnd%0d_%h_%h", i, ra, rb));
      end

      @(negedge clk);
      d_a = 64'h3FF0000000000000; d_b = 64'h4008000000000000; d_in_valid = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      lat = 0;
      while (!d_out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("dp_lat", 64'(lat), 64'd56);
      check("dp_res", d_result, 64'h3FD5555555555555);
      check("dp_flg", 64'({d_dbz, d_ovf, d_udf, d_inv}), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
